// File: rtl/seg_decode_rx.sv
// seg_decode_rx: sync + debounce a 7-segment bus, decode to hex on valid/ready.
// Optional saturating invalid-pattern counter: define SEG_RX_ERRCNT_EN.
module seg_decode_rx #(
  parameter int unsigned STABLE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       f0,
  input  logic       f1,
  input  logic       f2,
  input  logic       f3,
  input  logic       f4,
  input  logic       f5,
  input  logic       f6,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       x0,
  output logic       x1,
  output logic       x2,
  output logic       x3,
  output logic       err
`ifdef SEG_RX_ERRCNT_EN
  ,output logic [7:0] err_count
`endif
);

  typedef enum logic {SETTLE, EMIT} state_t;

  localparam logic [7:0] CNT_HIT = 8'(STABLE - 1);

  state_t     state_q;
  state_t     state_d;
  logic [6:0] seg_raw;
  logic [6:0] s1;
  logic [6:0] s2;
  logic [6:0] prev;
  logic [7:0] cnt;
  logic [6:0] last_emit;
  logic [6:0] held_pat;
  logic [3:0] code_q;
  logic       err_q;
  logic [3:0] dec_code;
  logic       dec_err;
  logic       accept;
  logic       new_evt;
  logic       handoff;

  assign seg_raw = {f6, f5, f4, f3, f2, f1, f0};

  // Two-flop synchroniser followed by the comparison register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= seg_raw;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Stability counter; restarts after every handoff.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (handoff || (s2 != prev)) begin
      cnt <= '0;
    end else if (cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Reverse lookup of the hex segment table.
  always_comb begin
    dec_code = 4'h0;
    dec_err  = 1'b0;
    unique case (s2)
      7'h3F: dec_code = 4'h0;
      7'h06: dec_code = 4'h1;
      7'h5B: dec_code = 4'h2;
      7'h4F: dec_code = 4'h3;
      7'h66: dec_code = 4'h4;
      7'h6D: dec_code = 4'h5;
      7'h7D: dec_code = 4'h6;
      7'h07: dec_code = 4'h7;
      7'h7F: dec_code = 4'h8;
      7'h6F: dec_code = 4'h9;
      7'h77: dec_code = 4'hA;
      7'h7C: dec_code = 4'hB;
      7'h39: dec_code = 4'hC;
      7'h5E: dec_code = 4'hD;
      7'h79: dec_code = 4'hE;
      7'h71: dec_code = 4'hF;
      default: dec_err = 1'b1;
    endcase
  end

  assign accept  = (state_q == SETTLE) && (s2 == prev) && (cnt == CNT_HIT);
  assign new_evt = accept && (s2 != last_emit) && (s2 != 7'h00);
  assign handoff = (state_q == EMIT) && out_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SETTLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: wait for a new stable pattern, then hold until taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SETTLE: if (new_evt) state_d = EMIT;
      EMIT:   if (out_ready) state_d = SETTLE;
      default: state_d = SETTLE;
    endcase
  end

  // Result capture and repeat-suppression memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q    <= '0;
      err_q     <= 1'b0;
      held_pat  <= '0;
      last_emit <= '0;
    end else begin
      if (new_evt) begin
        code_q   <= dec_err ? 4'h0 : dec_code;
        err_q    <= dec_err;
        held_pat <= s2;
      end
      if (handoff) begin
        last_emit <= held_pat;
      end else if (accept && (s2 == 7'h00)) begin
        last_emit <= 7'h00;
      end
    end
  end

`ifdef SEG_RX_ERRCNT_EN
  // Count handed-off invalid patterns, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (handoff && err_q && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

  assign out_valid = (state_q == EMIT);
  assign {x3, x2, x1, x0} = code_q;
  assign err = err_q;

endmodule

// File: tb/tb_seg_decode_rx.sv
// tb_seg_decode_rx: directed and random checks of seg_decode_rx
// against a sample-run reference model and a result scoreboard.
module tb_seg_decode_rx;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg;
  logic       out_ready;
  logic       out_valid;
  logic       x0, x1, x2, x3;
  logic       err;
`ifdef SEG_RX_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int total = 0;
  int bad = 0;
  int evt_n = 0;
  logic [3:0] last_x;
  logic       last_err;
  bit         sb_en = 0;
  logic [4:0] sb_q[$];
  logic [7:0] m_cur;
  int         m_run;
  logic [6:0] m_last;

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                           7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                           7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seg_decode_rx #(.STABLE(STABLE)) dut (
    .clk(clk),
    .reset(reset),
    .f0(seg[0]),
    .f1(seg[1]),
    .f2(seg[2]),
    .f3(seg[3]),
    .f4(seg[4]),
    .f5(seg[5]),
    .f6(seg[6]),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .x0(x0),
    .x1(x1),
    .x2(x2),
    .x3(x3),
    .err(err)
`ifdef SEG_RX_ERRCNT_EN
    ,.err_count(err_count)
`endif
  );

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_dec(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (tbl[i] == p) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  // A value held for STABLE+1 clock samples is accepted once.
  task automatic model_sample(input logic [6:0] v);
    if ({1'b0, v} != m_cur) begin
      m_cur = {1'b0, v};
      m_run = 1;
    end else begin
      m_run++;
    end
    if (m_run == STABLE + 1) begin
      if (v == 7'h00) begin
        m_last = 7'h00;
      end else if (v != m_last) begin
        sb_q.push_back(ref_dec(v));
        m_last = v;
      end
    end
  endtask

  // Count handoffs; compare against the scoreboard when enabled.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      evt_n++;
      last_x   = {x3, x2, x1, x0};
      last_err = err;
      if (sb_en) begin
        if (sb_q.size() == 0) check("sb_extra", 16'd1, 16'd0);
        else check("sb_evt", {11'd0, err, x3, x2, x1, x0},
                   {11'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
  endtask

  initial begin
    bit ok;
    bit hold;
    int ev0;
    reset = 1'b1;
    seg = 7'h06;
    out_ready = 1'b1;
    cyc(3);
    check("rst_valid", {15'd0, out_valid}, 16'd0);
    check("rst_x", {12'd0, x3, x2, x1, x0}, 16'd0);
    check("rst_err", {15'd0, err}, 16'd0);
`ifdef SEG_RX_ERRCNT_EN
    check("rst_errcnt", {8'd0, err_count}, 16'd0);
`endif
    reset = 1'b0;

    cyc(STABLE + 2);
    check("lat_early", {15'd0, out_valid}, 16'd0);
    cyc(1);
    check("lat_valid", {15'd0, out_valid}, 16'd1);
    check("lat_x", {12'd0, x3, x2, x1, x0}, 16'h1);
    check("lat_err", {15'd0, err}, 16'd0);
    cyc(50);
    check("hold_once", 16'(evt_n), 16'd1);

    out_ready = 1'b0;
    seg = 7'h7F;
    wait_valid(20, ok);
    check("bp_to", {15'd0, ok}, 16'd1);
    check("bp_x", {12'd0, x3, x2, x1, x0}, 16'h8);
    hold = 1;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) seg = 7'h3F;
      cyc(1);
      hold &= out_valid && ({x3, x2, x1, x0} == 4'h8) && !err;
    end
    check("bp_hold", {15'd0, hold}, 16'd1);
    ev0 = evt_n;
    out_ready = 1'b1;
    cyc(1);
    check("bp_drop", {15'd0, out_valid}, 16'd0);
    check("bp_take", 16'(evt_n - ev0), 16'd1);
    wait_valid(20, ok);
    check("bp2_to", {15'd0, ok}, 16'd1);
    check("bp2_x", {11'd0, err, x3, x2, x1, x0}, 16'h0);
    cyc(5);

    ev0 = evt_n;
    seg = 7'h5B;
    cyc(12);
    seg = 7'h4F;
    cyc(STABLE - 1);
    seg = 7'h5B;
    cyc(20);
    check("glitch_n", 16'(evt_n - ev0), 16'd1);
    check("glitch_x", {11'd0, last_err, last_x}, 16'h2);

    ev0 = evt_n;
    seg = 7'h00;
    cyc(10);
    seg = 7'h5B;
    cyc(12);
    check("blank_n", 16'(evt_n - ev0), 16'd1);
    check("blank_x", {11'd0, last_err, last_x}, 16'h2);

    ev0 = evt_n;
    seg = 7'h55;
    cyc(12);
    check("inv_n", 16'(evt_n - ev0), 16'd1);
    check("inv_x", {11'd0, last_err, last_x}, 16'h10);
`ifdef SEG_RX_ERRCNT_EN
    check("errcnt_1", {8'd0, err_count}, 16'd1);
    for (int i = 0; i < 300; i++) begin
      seg = (i % 2 == 0) ? 7'h2A : 7'h55;
      cyc(STABLE + 2);
    end
    cyc(4);
    check("errcnt_sat", {8'd0, err_count}, 16'd255);
`endif

    out_ready = 1'b0;
    seg = 7'h66;
    wait_valid(20, ok);
    check("rst_emit_to", {15'd0, ok}, 16'd1);
    check("rst_emit_x", {12'd0, x3, x2, x1, x0}, 16'h4);
    #2 reset = 1'b1;
    #1 check("rst_async", {15'd0, out_valid}, 16'd0);
    cyc(2);
    reset = 1'b0;
    out_ready = 1'b1;
    wait_valid(20, ok);
    check("rst_again_to", {15'd0, ok}, 16'd1);
    check("rst_again_x", {11'd0, err, x3, x2, x1, x0}, 16'h4);
    cyc(3);

    seg = 7'h00;
    do_reset();
    m_cur = 8'h80;
    m_run = 0;
    m_last = 7'h00;
    sb_en = 1;
    for (int s = 0; s < 80; s++) begin
      logic [6:0] v;
      int d;
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) v = tbl[$urandom_range(0, 15)];
      else if (r == 7) v = 7'h00;
      else v = 7'($urandom());
      if ($urandom_range(0, 9) < 3) d = $urandom_range(1, STABLE - 1);
      else d = $urandom_range(STABLE + 2, STABLE + 12);
      for (int c = 0; c < d; c++) begin
        seg = v;
        model_sample(v);
        cyc(1);
      end
    end
    for (int c = 0; c < 20; c++) begin
      model_sample(seg);
      cyc(1);
    end
    sb_en = 0;
    check("sb_left", 16'(sb_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
